// File: rtl/firebird7_in_gate2_tessent_tdr_seq_ctrl_if.sv
// IJTAG scan-port bundle between the gate2 local SIB and the seq-ctrl TDR.
// master: SIB/network side driving select, scan-in and the enables.
// slave:  TDR side returning scan-out.
interface firebird7_in_gate2_tessent_tdr_seq_ctrl_if;
  logic ijtag_sel;
  logic ijtag_si;
  logic ijtag_ce;
  logic ijtag_se;
  logic ijtag_ue;
  logic ijtag_so;

  modport master (
    output ijtag_sel,
    output ijtag_si,
    output ijtag_ce,
    output ijtag_se,
    output ijtag_ue,
    input  ijtag_so
  );

  modport slave (
    input  ijtag_sel,
    input  ijtag_si,
    input  ijtag_ce,
    input  ijtag_se,
    input  ijtag_ue,
    output ijtag_so
  );
endinterface

// File: rtl/firebird7_in_gate2_tessent_tdr_seq_ctrl.sv
// gate2 seq-ctrl TDR: IJTAG-written run/count word driving a cycle-count
// sequencer that gates an instrument enable; busy/done/remaining captured back.
// Optional: define TDR_UPDATE_PARITY_EN for an even-parity MSB on the shift
// register, checked on update, with a sticky parity_err.
module firebird7_in_gate2_tessent_tdr_seq_ctrl #(
  parameter int unsigned COUNT_W = 6
) (
  input  logic ijtag_tck,
  input  logic ijtag_reset,
  firebird7_in_gate2_tessent_tdr_seq_ctrl_if.slave ijtag,
  output logic run_en,
  output logic done,
  output logic parity_err
);

  localparam int unsigned DATA_WIDTH = COUNT_W + 2;
`ifdef TDR_UPDATE_PARITY_EN
  localparam int unsigned SR_W = DATA_WIDTH + 1;
`else
  localparam int unsigned SR_W = DATA_WIDTH;
`endif
  localparam logic [COUNT_W-1:0] CntOne = 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  logic [SR_W-1:0]       sr;
  logic [SR_W-1:0]       cap_word;
  logic [DATA_WIDTH-1:0] ur;
  logic                  run_q;
  logic                  start;
  logic                  so_latch;
  logic [COUNT_W-1:0]    cnt_q, cnt_d;
  state_e                state_q, state_d;

  // ur[1] is reserved in the field map
  logic unused_ur;
  assign unused_ur = ur[1];

`ifdef TDR_UPDATE_PARITY_EN
  logic parity_err_q;
  assign cap_word   = {parity_err_q, cnt_q, state_q == StDone, state_q == StRun};
  assign parity_err = parity_err_q;
`else
  assign cap_word   = {cnt_q, state_q == StDone, state_q == StRun};
  assign parity_err = 1'b0;
`endif

  // Capture/shift register; capture wins over shift, both need select
  always_ff @(posedge ijtag_tck) begin
    if (ijtag.ijtag_ce && ijtag.ijtag_sel) begin
      sr <= cap_word;
    end else if (ijtag.ijtag_se && ijtag.ijtag_sel) begin
      sr <= {ijtag.ijtag_si, sr[SR_W-1:1]};
    end
  end

  // Scan-out retimed to the falling edge: latch is transparent while tck is low
  always_latch begin
    if (!ijtag_tck) begin
      so_latch = sr[0];
    end
  end
  assign ijtag.ijtag_so = so_latch;

`ifdef TDR_UPDATE_PARITY_EN
  // Update register; a write with bad parity is dropped and flagged
  always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      ur           <= '0;
      parity_err_q <= 1'b0;
    end else if (ijtag.ijtag_ue && ijtag.ijtag_sel) begin
      if (^sr == 1'b0) begin
        ur           <= sr[DATA_WIDTH-1:0];
        parity_err_q <= 1'b0;
      end else begin
        parity_err_q <= 1'b1;
      end
    end
  end
`else
  // Update register loaded from the shift register on a selected update
  always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      ur <= '0;
    end else if (ijtag.ijtag_ue && ijtag.ijtag_sel) begin
      ur <= sr;
    end
  end
`endif

  // Sequencer state, counter and run-bit history for edge detection
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= ur[0];
    end
  end

  // Only a fresh 0->1 on the run bit starts a sequence
  assign start = ur[0] & ~run_q;

  // Sequencer next-state: N loaded gives N+1 RUN cycles, abort keeps the count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d   = ur[COUNT_W+1:2];
          state_d = StRun;
        end
      end
      StRun: begin
        if (!ur[0]) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StDone: begin
        cnt_d = '0;
        if (!ur[0]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign run_en = (state_q == StRun);
  assign done   = (state_q == StDone);

endmodule
